// File: rtl/prbs_rx_check_pkg.sv
// Shared PRBS definitions: the 24-bit LFSR step, the start pattern, the transmitter's
// error-injection mask and the checker FSM states.
package prbs_rx_check_pkg;

  localparam logic [47:0] START_PATTERN = 48'hFFFFFF000000;
  localparam logic [47:0] ERR_INJ_MASK  = 48'h608000400100;
  localparam int          LOCK_GOOD     = 4;
  localparam int          LOSS_BAD      = 4;
  localparam int          CNT_W         = 3;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } rx_state_e;

  function automatic logic [23:0] prbs_step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  // Word that follows w = {H, L}: the low half is the newest LFSR state.
  function automatic logic [47:0] prbs_next_word(input logic [47:0] w);
    logic [23:0] a;
    a = prbs_step(w[23:0]);
    return {a, prbs_step(a)};
  endfunction

endpackage

// File: rtl/prbs_rx_check_if.sv
// Receive-side bus between the link and the PRBS checker, plus the checker status outputs.
interface prbs_rx_check_if #(
  parameter int ERR_W = 16
);
  logic             DATA_VALID;
  logic [47:0]      RX_DATA;
  logic             STRT_LTNCY;
  logic             CLR_CNT;
  logic             SYNC;
  logic             ERR;
  logic [ERR_W-1:0] ERR_CNT;
  logic [7:0]       LATENCY;
  logic             LTNCY_VALID;
  logic [23:0]      BIT_ERR_CNT;

  modport master (
    output DATA_VALID, RX_DATA, STRT_LTNCY, CLR_CNT,
    input  SYNC, ERR, ERR_CNT, LATENCY, LTNCY_VALID, BIT_ERR_CNT
  );

  modport slave (
    input  DATA_VALID, RX_DATA, STRT_LTNCY, CLR_CNT,
    output SYNC, ERR, ERR_CNT, LATENCY, LTNCY_VALID, BIT_ERR_CNT
  );
endinterface

// File: rtl/prbs_rx_check_predict.sv
// Predictor register: seeds from a received word or flywheels from its own last prediction.
module prbs_rx_predict
  import prbs_rx_check_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        seed_i,
  input  logic        advance_i,
  input  logic [47:0] data_i,
  output logic [47:0] expected_o
);
  logic [47:0] pred_q, pred_d;

  always_comb begin
    pred_d = pred_q;
    if (seed_i) begin
      pred_d = prbs_next_word(data_i);
    end else if (advance_i) begin
      pred_d = prbs_next_word(pred_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_q <= '0;
    end else begin
      pred_q <= pred_d;
    end
  end

  assign expected_o = pred_q;

endmodule

// File: rtl/prbs_rx_check.sv
// PRBS receive checker: hunt/check/locked sync FSM, word-error and latency counters.
// Define PRBS_RX_BITERR_EN to build the saturating bit-error counter.
module prbs_rx_check
  import prbs_rx_check_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  prbs_rx_check_if.slave rx_if
);
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d;
  logic             err_q, strt_q, armed_q, ltncy_valid_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [7:0]       latency_q;
  logic [47:0]      expected;
  logic             is_start, word_live, consistent, match, strt_rise;
  logic             seed, advance, locked_miss;

  assign is_start   = rx_if.DATA_VALID && (rx_if.RX_DATA == START_PATTERN);
  assign word_live  = rx_if.DATA_VALID && !is_start;
  assign consistent = (rx_if.RX_DATA[23:0] == prbs_step(rx_if.RX_DATA[47:24]));
  assign match      = (rx_if.RX_DATA == expected);
  assign strt_rise  = rx_if.STRT_LTNCY && !strt_q;

  prbs_rx_predict u_predict (
    .clk_i      (CLK),
    .rst_i      (RST),
    .seed_i     (seed),
    .advance_i  (advance),
    .data_i     (rx_if.RX_DATA),
    .expected_o (expected)
  );

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    bad_d       = bad_q;
    seed        = 1'b0;
    advance     = 1'b0;
    locked_miss = 1'b0;
    if (is_start) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end else if (rx_if.DATA_VALID) begin
      case (state_q)
        HUNT: begin
          if (consistent) begin
            seed    = 1'b1;
            good_d  = CNT_W'(1);
            state_d = CHECK;
          end
        end
        CHECK: begin
          advance = 1'b1;
          if (match) begin
            good_d = good_q + CNT_W'(1);
            if (good_q == CNT_W'(LOCK_GOOD - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        LOCKED: begin
          advance = 1'b1;
          if (!match) begin
            locked_miss = 1'b1;
            good_d      = '0;
            bad_d       = bad_q + CNT_W'(1);
            if (bad_q == CNT_W'(LOSS_BAD - 1)) begin
              state_d = HUNT;
              bad_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HUNT;
      good_q    <= '0;
      bad_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= locked_miss;
      if (rx_if.CLR_CNT) begin
        err_cnt_q <= '0;
      end else if (locked_miss && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  // A rise with a live word in the same cycle measures zero and finishes at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      strt_q        <= 1'b0;
      armed_q       <= 1'b0;
      latency_q     <= '0;
      ltncy_valid_q <= 1'b0;
    end else begin
      strt_q <= rx_if.STRT_LTNCY;
      if (strt_rise) begin
        armed_q <= !word_live;
      end else if (word_live) begin
        armed_q <= 1'b0;
      end
      if (rx_if.CLR_CNT) begin
        latency_q     <= '0;
        ltncy_valid_q <= 1'b0;
      end else if (strt_rise) begin
        latency_q     <= '0;
        ltncy_valid_q <= word_live;
      end else if (armed_q) begin
        if (latency_q != 8'hFF) begin
          latency_q <= latency_q + 8'd1;
        end
        if (word_live) begin
          ltncy_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef PRBS_RX_BITERR_EN
  logic [23:0] bit_err_q;
  logic [5:0]  bit_diff;
  logic [24:0] bit_sum;

  assign bit_diff = 6'($countones(rx_if.RX_DATA ^ expected));
  assign bit_sum  = {1'b0, bit_err_q} + 25'(bit_diff);

  always_ff @(posedge CLK) begin
    if (RST || rx_if.CLR_CNT) begin
      bit_err_q <= '0;
    end else if (locked_miss) begin
      bit_err_q <= bit_sum[24] ? 24'hFFFFFF : bit_sum[23:0];
    end
  end

  assign rx_if.BIT_ERR_CNT = bit_err_q;
`else
  assign rx_if.BIT_ERR_CNT = '0;
`endif

  assign rx_if.SYNC        = (state_q == LOCKED);
  assign rx_if.ERR         = err_q;
  assign rx_if.ERR_CNT     = err_cnt_q;
  assign rx_if.LATENCY     = latency_q;
  assign rx_if.LTNCY_VALID = ltncy_valid_q;

endmodule

// File: tb/tb_prbs_rx_check.sv
// Randomized bench for prbs_rx_check against a cycle-level behavioural model; a 3-bit
// error-counter instance runs in parallel to reach counter saturation quickly.
module tb_prbs_rx_check;

  localparam logic [47:0] START_W = 48'hFFFFFF000000;
  localparam logic [47:0] INJ_W   = 48'h608000400100;
  localparam int M_HUNT   = 0;
  localparam int M_CHECK  = 1;
  localparam int M_LOCKED = 2;

  logic        clk;
  logic        rst, dv, strt, clr;
  logic [47:0] rxd;

  prbs_rx_check_if #(.ERR_W(16)) bus ();
  prbs_rx_check_if #(.ERR_W(3))  bus_s ();

  assign bus.DATA_VALID   = dv;
  assign bus.RX_DATA      = rxd;
  assign bus.STRT_LTNCY   = strt;
  assign bus.CLR_CNT      = clr;
  assign bus_s.DATA_VALID = dv;
  assign bus_s.RX_DATA    = rxd;
  assign bus_s.STRT_LTNCY = strt;
  assign bus_s.CLR_CNT    = clr;

  prbs_rx_check #(.ERR_W(16)) dut (.CLK(clk), .RST(rst), .rx_if(bus));
  prbs_rx_check #(.ERR_W(3))  dut_s (.CLK(clk), .RST(rst), .rx_if(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model state
  int          m_mode, m_good, m_bad, m_errs, m_bits, m_lat;
  bit          m_armed, m_lval, m_sprev, m_err;
  logic [47:0] m_exp;
  logic [23:0] tx_a;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [23:0] stp(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  function automatic logic [47:0] nxt(input logic [47:0] w);
    logic [23:0] a;
    a = stp(w[23:0]);
    return {a, stp(a)};
  endfunction

  function automatic longint satv(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  function automatic logic [47:0] tx_next();
    logic [47:0] w;
    w    = {tx_a, stp(tx_a)};
    tx_a = stp(stp(tx_a));
    return w;
  endfunction

  task automatic model_cycle(input logic r, input logic v, input logic [47:0] d,
                             input logic s, input logic c);
    bit is_st, live, rise;
    if (r) begin
      m_mode = M_HUNT; m_good = 0; m_bad = 0; m_exp = '0; m_errs = 0; m_bits = 0;
      m_lat = 0; m_armed = 0; m_lval = 0; m_sprev = 0; m_err = 0;
      return;
    end
    rise    = s && !m_sprev;
    m_sprev = s;
    m_err   = 0;
    is_st   = v && (d == START_W);
    live    = v && !is_st;
    if (is_st) begin
      m_mode = M_HUNT; m_good = 0; m_bad = 0;
    end else if (v) begin
      if (m_mode == M_HUNT) begin
        if (d[23:0] == stp(d[47:24])) begin
          m_exp = nxt(d); m_good = 1; m_mode = M_CHECK;
        end
      end else if (m_mode == M_CHECK) begin
        if (d == m_exp) begin
          m_good++;
          if (m_good == 4) begin m_mode = M_LOCKED; m_bad = 0; end
        end else begin
          m_mode = M_HUNT; m_good = 0;
        end
        m_exp = nxt(m_exp);
      end else begin
        if (d != m_exp) begin
          m_err = 1; m_errs++; m_bits += $countones(d ^ m_exp);
          m_bad++; m_good = 0;
          if (m_bad == 4) begin m_mode = M_HUNT; m_bad = 0; end
        end else begin
          m_bad = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (rise) begin
      m_lat = 0; m_armed = !live; m_lval = live;
    end else if (m_armed) begin
      m_lat++;
      if (live) begin m_armed = 0; m_lval = 1; end
    end
    if (c) begin m_errs = 0; m_bits = 0; m_lat = 0; m_lval = 0; end
  endtask

  // One clock: apply inputs, advance the model, compare every output.
  task automatic tick(input logic v, input logic [47:0] d);
    dv  = v;
    rxd = d;
    @(posedge clk);
    #1;
    model_cycle(rst, v, d, strt, clr);
    check_val("sync", bus.SYNC, 64'(m_mode == M_LOCKED));
    check_val("err", bus.ERR, 64'(m_err));
    check_val("err_cnt", bus.ERR_CNT, satv(m_errs, 65535));
    check_val("err_cnt_w3", bus_s.ERR_CNT, satv(m_errs, 7));
    check_val("latency", bus.LATENCY, satv(m_lat, 255));
    check_val("ltncy_valid", bus.LTNCY_VALID, 64'(m_lval));
`ifdef PRBS_RX_BITERR_EN
    check_val("bit_err_cnt", bus.BIT_ERR_CNT, satv(m_bits, 24'hFFFFFF));
`else
    check_val("bit_err_cnt", bus.BIT_ERR_CNT, 64'd0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, rnd48());
  endtask

  task automatic tx_tick(input logic [47:0] mask);
    tick(1'b1, tx_next() ^ mask);
  endtask

  int lat_d;

  initial begin
    rst = 1'b1; strt = 1'b0; clr = 1'b0; dv = 1'b0; rxd = '0;
    tx_a = 24'h83B62E;
    model_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, rnd48());
    check_val("reset_sync", bus.SYNC, 64'd0);
    check_val("reset_ltncy_valid", bus.LTNCY_VALID, 64'd0);
    rst = 1'b0;

    // Idle link, then strobe and a clean stream after a random link delay
    repeat (4) begin tick(1'b1, START_W); idle(1); end
    lat_d = $urandom_range(4, 20);
    strt  = 1'b1;
    repeat (lat_d) tick(1'b0, START_W);
    for (int i = 0; i < 6; i++) begin
      tx_tick('0);
      if (i == 2) check_val("sync_after_3_good", bus.SYNC, 64'd0);
      if (i == 3) check_val("sync_after_4_good", bus.SYNC, 64'd1);
      idle(1);
    end
    check_val("clean_err_cnt", bus.ERR_CNT, 64'd0);
    check_val("link_latency", bus.LATENCY, 64'(lat_d));
    check_val("link_ltncy_valid", bus.LTNCY_VALID, 64'd1);
    strt = 1'b0;

    // Single injected error while locked
    tx_tick(INJ_W);
    check_val("inj_err_pulse", bus.ERR, 64'd1);
    check_val("inj_err_cnt", bus.ERR_CNT, 64'd1);
    check_val("inj_sync_held", bus.SYNC, 64'd1);
`ifdef PRBS_RX_BITERR_EN
    check_val("inj_bit_err_cnt", bus.BIT_ERR_CNT, 64'd5);
`endif
    idle(1);
    check_val("inj_err_one_cycle", bus.ERR, 64'd0);
    repeat (3) begin tx_tick('0); idle(1); end

    // Four consecutive corrupted words drop sync, four clean words regain it
    for (int i = 0; i < 4; i++) begin
      tx_tick(rnd48() | 48'h1);
      if (i == 2) check_val("loss_sync_after_3", bus.SYNC, 64'd1);
      if (i == 3) check_val("loss_sync_after_4", bus.SYNC, 64'd0);
      idle(1);
    end
    check_val("loss_err_cnt", bus.ERR_CNT, 64'd5);
    for (int i = 0; i < 4; i++) begin
      tx_tick('0);
      if (i == 2) check_val("relock_after_3", bus.SYNC, 64'd0);
      if (i == 3) check_val("relock_after_4", bus.SYNC, 64'd1);
      idle(1);
    end

    // Start pattern while locked: back to hunt, counters kept
    tick(1'b1, START_W);
    check_val("start_sync", bus.SYNC, 64'd0);
    check_val("start_err_cnt_kept", bus.ERR_CNT, 64'd5);
    check_val("start_lval_kept", bus.LTNCY_VALID, 64'd1);
    idle(1);

    // Corrupt the second word during CHECK
    tx_tick('0); idle(1);
    tx_tick(INJ_W);
    check_val("check_miss_sync", bus.SYNC, 64'd0);
    check_val("check_miss_err_cnt", bus.ERR_CNT, 64'd5);
    idle(1);
    repeat (4) begin tx_tick('0); idle(1); end
    check_val("check_miss_relock", bus.SYNC, 64'd1);

    // Error bursts: the 3-bit counter saturates, the 16-bit one keeps counting
    repeat (4) begin
      repeat (3) begin tx_tick(rnd48() | 48'h1); idle(1); end
      tx_tick('0); idle(1);
    end
    check_val("burst_err_cnt", bus.ERR_CNT, 64'd17);
    check_val("sat_err_cnt_w3", bus_s.ERR_CNT, 64'd7);
    check_val("burst_sync", bus.SYNC, 64'd1);

    // Clear coincident with an error
    clr = 1'b1;
    tx_tick(INJ_W);
    clr = 1'b0;
    check_val("clr_err_pulse", bus.ERR, 64'd1);
    check_val("clr_err_cnt", bus.ERR_CNT, 64'd0);
    check_val("clr_err_cnt_w3", bus_s.ERR_CNT, 64'd0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 49) == 0) strt = ~strt;
      clr = ($urandom_range(0, 99) == 0);
      if (r < 3)       tick(1'b1, START_W);
      else if (r < 15) tx_tick(rnd48() | 48'h1);
      else             tx_tick('0);
      clr = 1'b0;
      idle($urandom_range(0, 2));
    end

    // Reset in mid-stream
    repeat (6) begin tx_tick('0); idle(1); end
    rst = 1'b1;
    tx_tick('0);
    rst = 1'b0;
    check_val("rst_mid_sync", bus.SYNC, 64'd0);
    check_val("rst_mid_err_cnt", bus.ERR_CNT, 64'd0);
    check_val("rst_mid_latency", bus.LATENCY, 64'd0);
    check_val("rst_mid_ltncy_valid", bus.LTNCY_VALID, 64'd0);
    check_val("rst_mid_bit_err_cnt", bus.BIT_ERR_CNT, 64'd0);
    repeat (5) begin tx_tick('0); idle(1); end
    check_val("post_rst_relock", bus.SYNC, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prbs_rx_check.md
# prbs_rx_check

Receive-side PRBS checker that consumes the 48-bit words produced by the transmit PRBS generator after they cross the link. It hunts for the start pattern, self-seeds its own predictor from the incoming data, then flywheels and counts word errors. It also measures round-trip latency from the transmitter's start-of-sequence strobe. It sits directly downstream of the transmit generator, in the same clock domain, and feeds the test status registers.

## Interface
- START_PATTERN, 48'hFFFFFF000000, idle word the transmitter sends while held in reset
- LOCK_GOOD, 4, consecutive good words required to declare sync
- LOSS_BAD, 4, consecutive bad words while locked that drop sync
- ERR_W, 16, width of the word-error counter

Ports:
- CLK  in  1  the single clock (same clock as the transmitter's generator clock)
- RST  in  1  reset; synchronous, active-high
- DATA_VALID  in  1  RX_DATA holds a word this cycle (nominally every other cycle)
- RX_DATA  in  48  received word: {older 24-bit LFSR state, next state}
- STRT_LTNCY  in  1  transmitter strobe; goes high when the first PRBS word leaves
- CLR_CNT  in  1  synchronous clear of ERR_CNT, BIT_ERR_CNT, LATENCY, LTNCY_VALID
- SYNC  out  1  high in LOCKED
- ERR  out  1  one-cycle pulse per mismatched word while LOCKED
- ERR_CNT  out  ERR_W  saturating word-error count
- LATENCY  out  8  cycles from STRT_LTNCY rise to first checked word; saturates at 255
- LTNCY_VALID  out  1  LATENCY is final
- BIT_ERR_CNT  out  24  saturating bit-error count (see Configuration)

## Operation
- Step function, shared with the transmitter: step(s) = {s[22:0], s[23]^s[22]^s[21]^s[16]}.
- Predictor: from word W = {H, L}, the expected next word is {step(L), step(step(L))}.
- A word is consistent if L == step(H).
- FSM states:
  - HUNT:
    - A valid START_PATTERN word stays in HUNT.
    - A valid non-start consistent word loads the predictor from RX_DATA, sets good=1, and moves to CHECK.
    - Anything else stays in HUNT.
  - CHECK:
    - On each valid word, compare with the prediction.
    - A match increments good; good == LOCK_GOOD moves to LOCKED.
    - A mismatch returns to HUNT.
  - LOCKED:
    - A mismatch pulses ERR, increments ERR_CNT and bad, and returns good to 0.
    - A match clears bad.
    - bad == LOSS_BAD moves to HUNT.
  - In every state, a valid START_PATTERN word forces HUNT. The counters are kept.
- In CHECK and LOCKED the predictor advances from its own previous prediction (flywheel) on every valid word, match or not. A single corrupted word therefore costs exactly one error.
- Latency:
  - A rising edge of STRT_LTNCY clears LATENCY to 0, clears LTNCY_VALID, and arms the counter.
  - While armed, LATENCY increments every CLK cycle.
  - The first valid non-start word disarms the counter and sets LTNCY_VALID.
  - A new rising edge re-arms the counter.
- Counters saturate at all-ones and never wrap.
- CLR_CNT has priority over an increment in the same cycle.

## Timing
- Reset values:
  - state HUNT, SYNC=0, ERR=0, ERR_CNT=0, LATENCY=0, LTNCY_VALID=0, BIT_ERR_CNT=0.
  - The predictor and good/bad counters are 0 and STRT_LTNCY history is 0.
- A comparison uses the word registered on a DATA_VALID cycle. ERR, counter updates and state change are visible 1 cycle after that cycle.
- SYNC rises 1 cycle after the LOCK_GOOD-th consecutive good word.
- LATENCY counts the cycle of the detected edge as 0. The counter stops on the cycle DATA_VALID presents the first non-start word, and LTNCY_VALID rises 1 cycle later.
- DATA_VALID low:
  - no compare, no predictor advance, no state change.
  - the latency counter keeps running.
- RST mid-operation returns everything to reset values on the next edge.

## Configuration
- PRBS_RX_BITERR_EN defined:
  - BIT_ERR_CNT adds popcount(RX_DATA ^ expected) on each LOCKED mismatch, saturating.
  - CLR_CNT clears it.
- Not defined: BIT_ERR_CNT is tied to 0 and no popcount logic is built.

## Structure
- Shared package holds:
  - the 24-bit step function
  - the default start pattern
  - the transmitter error-injection mask 48'h608000400100
  - the FSM state enum (HUNT, CHECK, LOCKED)
- One sub-module, prbs_rx_predict, holds the predictor register. It supports seed-from-data and flywheel advance, and outputs the 48-bit expected word.
- FSM, counters and latency measurement live in the top module.

## Test plan
- Drive 4 START_PATTERN words, raise STRT_LTNCY, then send a clean PRBS stream seeded 24'h83B62E, 1 word every 2 cycles:
  - SYNC is high after the 4th good word.
  - ERR_CNT=0.
  - LATENCY equals the programmed link delay and LTNCY_VALID=1.
- While locked, XOR a single word with 48'h608000400100:
  - exactly 1 ERR pulse and ERR_CNT=1.
  - with PRBS_RX_BITERR_EN, BIT_ERR_CNT=5.
  - SYNC stays high.
- While locked, corrupt 4 consecutive words:
  - ERR_CNT += 4 and SYNC drops 1 cycle after the 4th.
  - the checker re-locks after 4 clean words.
- Corrupt the 2nd of the first 4 words in CHECK: the checker returns to HUNT, SYNC stays 0 and ERR_CNT is unchanged.
- Preset ERR_CNT to 16'hFFFE and inject 3 errors:
  - ERR_CNT holds at 16'hFFFF.
  - CLR_CNT asserted together with an error gives ERR_CNT=0.
- Assert RST mid-stream and, separately, send a START_PATTERN while LOCKED:
  - all outputs return to reset values and the state goes to HUNT.
  - the start pattern case keeps the counters.
